wb_master_bridge: RTL and testbench
===================================

Name: wb_master_bridge

Overview:
Wishbone classic initiator that drives the user-area slave port (wbs_* interface) from a simple valid/ready command stream. It serves as the on-chip/bench-side counterpart of the rift2Wrap slave port. Each accepted command issues exactly one single-beat Wishbone cycle, waits for ack or timeout, then returns one response. There are no bursts, and no pipelined stall/retry is supported.

Parameters:
ADDR_W, 32, Wishbone address width.
DATA_W, 32, Wishbone data width; the sel width is DATA_W/8.
TIMEOUT, 255, number of bus cycles to wait for ack before aborting; 0 disables the timeout.

Ports:
wb_clk_i  in  1  single clock; all logic is on the rising edge
wb_rst_i  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  bridge can accept a command
cmd_we  in  1  1 = write, 0 = read
cmd_adr  in  ADDR_W  byte address, passed unaltered to the bus
cmd_dat  in  DATA_W  write data
cmd_sel  in  DATA_W/8  byte enables
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_dat  out  DATA_W  read data; 0 for writes and for timeouts
rsp_err  out  1  1 = timeout abort
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  Wishbone write enable
wbm_adr_o  out  ADDR_W  Wishbone address
wbm_dat_o  out  DATA_W  Wishbone write data
wbm_sel_o  out  DATA_W/8  Wishbone byte select
wbm_dat_i  in  DATA_W  Wishbone read data
wbm_ack_i  in  1  Wishbone acknowledge

Behaviour:
- One clock, wb_clk_i. Reset is synchronous and active-high on wb_rst_i.
- Reset values:
  - cmd_ready=0 during reset, 1 on the first cycle after reset.
  - All other outputs are 0. The state machine is in IDLE and the timeout counter is 0.
- States are IDLE, BUS and RESP. All outputs are registered.
- IDLE:
  - cmd_ready=1, cyc=stb=0.
  - On cmd_valid&&cmd_ready: latch we/adr/dat/sel into the wbm_* registers, clear the counter, and go to BUS.
- BUS:
  - cyc=stb=1; we/adr/dat/sel are held stable; cmd_ready=0.
  - Each cycle without ack, the counter increments.
  - ack sampled high: capture wbm_dat_i into rsp_dat if it is a read (0 if a write), set rsp_err=0, deassert cyc/stb at the same edge, go to RESP.
  - TIMEOUT!=0 and counter==TIMEOUT-1 with no ack: deassert cyc/stb, set rsp_dat=0, rsp_err=1, go to RESP.
  - Ack and timeout in the same cycle: ack wins and rsp_err=0.
- RESP:
  - rsp_valid=1; rsp_dat and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On the handshake: rsp_valid=0, go to IDLE (cmd_ready=1 the next cycle).
- Latency:
  - Command accepted at edge N → cyc/stb high in cycle N+1.
  - Zero-wait-state ack in N+1 → rsp_valid in N+2.
  - Minimum command-to-command spacing is 3 cycles with rsp_ready tied high.
- wbm_ack_i outside BUS is ignored and changes no state.
- wbm_dat_o/adr/sel/we keep their last values when idle. Their value is don't-care while cyc=0, but it is deterministic.
- The counter width is clog2(TIMEOUT+1) and saturates without wrapping.
- wb_rst_i asserted in any state: at the next edge cyc/stb/rsp_valid=0 and the state returns to IDLE. The in-flight transaction is dropped and no response is emitted.
- cmd_* inputs are ignored unless in IDLE. rsp_ready is ignored unless in RESP.

Decomposition:
- Shared package wb_pkg holds:
  - state enum {IDLE, BUS, RESP};
  - default widths WB_ADDR_W=32, WB_DATA_W=32;
  - WB_TIMEOUT_DEFAULT=255;
  - localparam WB_RSP_TIMEOUT_DAT = '0.
- Single module; no sub-module is needed. The timeout counter is inline.

Test Plan:
1. Write: cmd we=1, adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF, slave acks after 2 wait states → cyc/stb high for 3 cycles with stable fields, then rsp_valid=1, rsp_err=0, rsp_dat=0.
2. Read: cmd we=0, adr=0x3000_0000, sel=0xF, slave acks the first cycle with dat_i=0xDEAD_BEEF → rsp_valid at N+2, rsp_dat=0xDEAD_BEEF, rsp_err=0.
3. Timeout with TIMEOUT=4, slave never acks → cyc high for exactly 4 cycles, then rsp_err=1, rsp_dat=0. A late ack after that is ignored and the state stays IDLE.
4. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_dat/err stable and cmd_ready=0 throughout. After rsp_ready=1, a second command is accepted and its bus cycle starts 2 cycles later.
5. Reset mid-BUS: wb_rst_i pulsed 1 cycle while cyc=1 → next cycle cyc=stb=rsp_valid=0, cmd_ready=1 after reset; no response is produced.
6. Ack on the timeout cycle (TIMEOUT=3, ack in the 3rd bus cycle, dat_i=0x1) → rsp_err=0, rsp_dat=0x1.

Source files
------------

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone classic master bridge:
//   - wb_state_e         : bridge FSM states (IDLE, BUS, RESP)
//   - WB_ADDR_W/WB_DATA_W: default bus widths
//   - WB_TIMEOUT_DEFAULT : default ack timeout in bus cycles (0 = disabled)
//   - WB_RSP_TIMEOUT_DAT : response data returned on a timeout abort
//   - wb_cnt_width()     : width of the timeout counter for a given TIMEOUT
// ---------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    localparam int WB_ADDR_W          = 32;
    localparam int WB_DATA_W          = 32;
    localparam int WB_TIMEOUT_DEFAULT = 255;

    localparam logic [WB_DATA_W-1:0] WB_RSP_TIMEOUT_DAT = '0;

    // clog2(timeout+1), never narrower than one bit so TIMEOUT=0 still builds
    function automatic int wb_cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_master_bridge.sv
// ---------------------------------------------------------------------------
// wb_master_bridge
// Wishbone classic initiator driven by a valid/ready command stream. Each
// accepted command produces exactly one single-beat bus cycle, which ends on
// ack or on timeout, followed by exactly one response on the rsp_* stream.
//
// Ports
//   wb_clk_i, wb_rst_i          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready         : command handshake
//   cmd_we/adr/dat/sel          : command fields (write flag, address, data, byte enables)
//   rsp_valid/rsp_ready         : response handshake
//   rsp_dat, rsp_err            : read data (0 for writes/timeouts), timeout flag
//   wbm_cyc_o/stb_o/we_o/adr_o/dat_o/sel_o : Wishbone master outputs
//   wbm_dat_i, wbm_ack_i        : Wishbone read data and acknowledge
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DATA_W  = WB_DATA_W,
    parameter int TIMEOUT = WB_TIMEOUT_DEFAULT
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    input  logic [DATA_W/8-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output logic                rsp_err,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i
);

    localparam int SEL_W  = DATA_W / 8;
    localparam int CNT_W  = wb_cnt_width(TIMEOUT);
    localparam bit TO_EN  = (TIMEOUT != 0);
    localparam int LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;

    // counter value on the last bus cycle before abort, and saturation value
    localparam logic [CNT_W-1:0] CNT_LAST = LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX  = TIMEOUT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    wb_state_e           state_r,     state_s;
    logic                cmd_ready_r, cmd_ready_s;
    logic                cyc_r,       cyc_s;
    logic                we_r,        we_s;
    logic [ADDR_W-1:0]   adr_r,       adr_s;
    logic [DATA_W-1:0]   dat_r,       dat_s;
    logic [SEL_W-1:0]    sel_r,       sel_s;
    logic                rsp_valid_r, rsp_valid_s;
    logic [DATA_W-1:0]   rsp_dat_r,   rsp_dat_s;
    logic                rsp_err_r,   rsp_err_s;
    logic [CNT_W-1:0]    cnt_r,       cnt_s;
    logic                timeout_hit_s;

    // Abort condition: counter reached the last permitted cycle (only when enabled)
    always_comb begin
        timeout_hit_s = 1'b0;
        if (TO_EN && (cnt_r == CNT_LAST)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Next-state and next-output logic for the IDLE/BUS/RESP sequencer
    always_comb begin
        state_s     = state_r;
        cmd_ready_s = cmd_ready_r;
        cyc_s       = cyc_r;
        we_s        = we_r;
        adr_s       = adr_r;
        dat_s       = dat_r;
        sel_s       = sel_r;
        rsp_valid_s = rsp_valid_r;
        rsp_dat_s   = rsp_dat_r;
        rsp_err_s   = rsp_err_r;
        cnt_s       = cnt_r;

        case (state_r)
            IDLE: begin
                // cmd_ready_r is still 0 for the first cycle out of reset,
                // so no command can be taken on that cycle
                if (cmd_valid && cmd_ready_r) begin
                    we_s        = cmd_we;
                    adr_s       = cmd_adr;
                    dat_s       = cmd_dat;
                    sel_s       = cmd_sel;
                    cnt_s       = {CNT_W{1'b0}};
                    cyc_s       = 1'b1;
                    cmd_ready_s = 1'b0;
                    state_s     = BUS;
                end else begin
                    cmd_ready_s = 1'b1;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    // ack has priority over a coincident timeout
                    cyc_s       = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_dat_s   = we_r ? {DATA_W{1'b0}} : wbm_dat_i;
                    rsp_err_s   = 1'b0;
                    state_s     = RESP;
                end else begin
                    if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                    if (timeout_hit_s) begin
                        cyc_s       = 1'b0;
                        rsp_valid_s = 1'b1;
                        rsp_dat_s   = WB_RSP_TIMEOUT_DAT[DATA_W-1:0];
                        rsp_err_s   = 1'b1;
                        state_s     = RESP;
                    end else begin
                        cyc_s = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    cmd_ready_s = 1'b1;
                    state_s     = IDLE;
                end else begin
                    rsp_valid_s = 1'b1;
                end
            end
            default: begin
                state_s     = IDLE;
                cyc_s       = 1'b0;
                rsp_valid_s = 1'b0;
                cmd_ready_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b0;
            cyc_r       <= 1'b0;
            we_r        <= 1'b0;
            adr_r       <= {ADDR_W{1'b0}};
            dat_r       <= {DATA_W{1'b0}};
            sel_r       <= {SEL_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_dat_r   <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            cmd_ready_r <= cmd_ready_s;
            cyc_r       <= cyc_s;
            we_r        <= we_s;
            adr_r       <= adr_s;
            dat_r       <= dat_s;
            sel_r       <= sel_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_dat_r   <= rsp_dat_s;
            rsp_err_r   <= rsp_err_s;
            cnt_r       <= cnt_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign wbm_cyc_o = cyc_r;
    assign wbm_stb_o = cyc_r;
    assign wbm_we_o  = we_r;
    assign wbm_adr_o = adr_r;
    assign wbm_dat_o = dat_r;
    assign wbm_sel_o = sel_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_dat   = rsp_dat_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_wb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_wb_master_bridge
// Directed and randomized transactions against wb_master_bridge (TIMEOUT=4).
// A slave model acks after a chosen number of wait states; the expected bus
// duration, error flag and response data are derived from the transaction
// description alone.
// ---------------------------------------------------------------------------
module tb_wb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_dat;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [SW-1:0] wbm_sel_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack_i;

    int n_checks = 0;
    int n_fail   = 0;

    wb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Junk on the command port; it must be ignored outside IDLE
    task automatic junk_cmd();
        cmd_valid = 1'b1;
        cmd_we    = 1'($urandom);
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = 4'($urandom);
    endtask

    // One complete transaction. waits = wait states before the slave acks,
    // hold = cycles rsp_ready stays low once the response is presented.
    task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                           input logic [SW-1:0] sel, input int waits, input logic [DW-1:0] rdat,
                           input int hold);
        logic          exp_err;
        int            n_bus;
        logic [DW-1:0] exp_dat;
        exp_err = (TO != 0) && (waits + 1 > TO);
        n_bus   = exp_err ? TO : waits + 1;
        exp_dat = (we || exp_err) ? 32'h0 : rdat;

        chk("idle_cmd_ready", cmd_ready, 1'b1);
        chk("idle_cyc", wbm_cyc_o, 1'b0);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        rsp_ready = 1'($urandom);
        step();
        junk_cmd();
        for (int k = 1; k <= n_bus; k++) begin
            chk("bus_cyc", wbm_cyc_o, 1'b1);
            chk("bus_stb", wbm_stb_o, 1'b1);
            chk("bus_we", wbm_we_o, we);
            chk("bus_adr", wbm_adr_o, adr);
            chk("bus_dat", wbm_dat_o, dat);
            chk("bus_sel", wbm_sel_o, sel);
            chk("bus_cmd_ready", cmd_ready, 1'b0);
            chk("bus_rsp_valid", rsp_valid, 1'b0);
            wbm_ack_i = (k == waits + 1);
            wbm_dat_i = wbm_ack_i ? rdat : $urandom;
            rsp_ready = 1'($urandom);
            junk_cmd();
            step();
        end
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i <= hold; i++) begin
            chk("rsp_valid", rsp_valid, 1'b1);
            chk("rsp_dat", rsp_dat, exp_dat);
            chk("rsp_err", rsp_err, exp_err);
            chk("rsp_cyc", wbm_cyc_o, 1'b0);
            chk("rsp_stb", wbm_stb_o, 1'b0);
            chk("rsp_cmd_ready", cmd_ready, 1'b0);
            if (i == hold) begin
                wbm_ack_i = 1'b0;
                rsp_ready = 1'b1;
                cmd_valid = 1'b0;
            end else begin
                wbm_ack_i = 1'($urandom);
                wbm_dat_i = $urandom;
                junk_cmd();
            end
            step();
        end
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 1'b0);
        chk("post_cmd_ready", cmd_ready, 1'b1);
        chk("post_cyc", wbm_cyc_o, 1'b0);
        chk("post_adr_held", wbm_adr_o, adr);
        chk("post_we_held", wbm_we_o, we);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wbm_dat_i = '0;
        wbm_ack_i = 1'b0;

        // reset state
        step(); step(); step();
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_cyc", wbm_cyc_o, 1'b0);
        chk("rst_stb", wbm_stb_o, 1'b0);
        chk("rst_we", wbm_we_o, 1'b0);
        chk("rst_adr", wbm_adr_o, 32'h0);
        chk("rst_dat", wbm_dat_o, 32'h0);
        chk("rst_sel", wbm_sel_o, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_dat", rsp_dat, 32'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        rst = 1'b0;
        step();
        chk("first_cmd_ready", cmd_ready, 1'b1);

        // write with 2 wait states
        run_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 2, 32'h5555_AAAA, 0);
        // read, zero wait states, back-to-back
        run_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 0);
        // timeout: slave never acks
        run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 100, 32'hFFFF_FFFF, 0);
        // late ack in IDLE is ignored
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h1234_5678;
        step();
        wbm_ack_i = 1'b0;
        chk("late_ack_cyc", wbm_cyc_o, 1'b0);
        chk("late_ack_rsp_valid", rsp_valid, 1'b0);
        chk("late_ack_cmd_ready", cmd_ready, 1'b1);
        // backpressure, then a follow-up command
        run_txn(1'b0, 32'h3000_0020, 32'h0, 4'h3, 1, 32'hCAFE_F00D, 5);
        run_txn(1'b1, 32'h3000_0024, 32'h0BAD_F00D, 4'h1, 0, 32'h0, 0);
        // ack on the timeout cycle: ack wins
        run_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, TO - 1, 32'h0000_0001, 0);

        // reset mid-BUS
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0040;
        cmd_sel   = 4'hF;
        step();
        cmd_valid = 1'b0;
        chk("mid_bus_cyc", wbm_cyc_o, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_cyc", wbm_cyc_o, 1'b0);
        chk("mid_rst_stb", wbm_stb_o, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
        step();
        chk("after_rst_cmd_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wbm_ack_i = 1'($urandom);
            step();
            chk("after_rst_no_rsp", rsp_valid, 1'b0);
            chk("after_rst_no_cyc", wbm_cyc_o, 1'b0);
        end
        wbm_ack_i = 1'b0;

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 6), $urandom, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
